// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative radix-2 multiply/divide unit for the RV32M operations.
// Shift-add multiply and restoring divide on operand magnitudes. Signs are
// corrected in a final fix-up cycle. Divide-by-zero, signed overflow and unknown
// opcodes bypass the datapath and commit at the accepting edge.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   valid_i  request valid; accepted when valid_i & ready_o & !flush
//   A, B     operands (dividend/multiplicand, divisor/multiplier)
//   ALUCtrl  5-bit operation code, sampled at accept
//   flush    kill any in-flight operation
//   ready_o  unit can accept a request this cycle
//   valid_o  one-cycle pulse: Y/ZERO hold a new result
//   Y        result, held until the next result
//   ZERO     registered (Y == 0)
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUCtrl,
    input  logic             flush,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO
);

    localparam logic [4:0] OpMul    = 5'b01111;
    localparam logic [4:0] OpMulh   = 5'b10000;
    localparam logic [4:0] OpMulhsu = 5'b10001;
    localparam logic [4:0] OpMulhu  = 5'b10010;
    localparam logic [4:0] OpDiv    = 5'b01101;
    localparam logic [4:0] OpDivu   = 5'b01110;
    localparam logic [4:0] OpRem    = 5'b10011;
    localparam logic [4:0] OpRemu   = 5'b10100;

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod_q;   // multiply: {hi, lo}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   y_q;
    logic               zero_q;

    // Request decode
    logic             accept, is_mul, is_div, known, a_signed, b_signed, sa, sb;
    logic             div_zero, ovf, fast;
    logic [WIDTH-1:0] a_mag, b_mag, fast_val;

    always_comb begin
        accept   = valid_i & ready_o & ~flush;
        is_mul   = (ALUCtrl == OpMul) | (ALUCtrl == OpMulh) | (ALUCtrl == OpMulhsu) |
                   (ALUCtrl == OpMulhu);
        is_div   = (ALUCtrl == OpDiv) | (ALUCtrl == OpDivu) | (ALUCtrl == OpRem) |
                   (ALUCtrl == OpRemu);
        known    = is_mul | is_div;
        a_signed = (ALUCtrl == OpMul) | (ALUCtrl == OpMulh) | (ALUCtrl == OpMulhsu) |
                   (ALUCtrl == OpDiv) | (ALUCtrl == OpRem);
        b_signed = (ALUCtrl == OpMul) | (ALUCtrl == OpMulh) | (ALUCtrl == OpDiv) |
                   (ALUCtrl == OpRem);
        sa       = a_signed & A[WIDTH-1];
        sb       = b_signed & B[WIDTH-1];
        a_mag    = sa ? -A : A;
        b_mag    = sb ? -B : B;
        div_zero = is_div & (B == '0);
        ovf      = ((ALUCtrl == OpDiv) | (ALUCtrl == OpRem)) & (A == MinNeg) & (B == '1);
        fast     = ~known | div_zero | ovf;
        fast_val = '0;
        if (div_zero) begin
            fast_val = ((ALUCtrl == OpDiv) | (ALUCtrl == OpDivu)) ? '1 : A;
        end else if (ovf) begin
            fast_val = (ALUCtrl == OpDiv) ? A : '0;
        end
    end

    // One radix-2 step of either datapath
    logic               op_mul_q;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] step_val;

    always_comb begin
        op_mul_q  = (op_q == OpMul) | (op_q == OpMulh) | (op_q == OpMulhsu) |
                    (op_q == OpMulhu);
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_mul_q) begin
            step_val = {mul_sum, prod_q[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            step_val = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end else begin
            step_val = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and result selection
    logic [2*WIDTH-1:0] full_prod;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_val;

    always_comb begin
        full_prod = neg_q ? -prod_q : prod_q;
        q_fix     = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        r_fix     = neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OpMul:                     fix_val = full_prod[WIDTH-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_val = full_prod[2*WIDTH-1:WIDTH];
            OpDiv, OpDivu:             fix_val = q_fix;
            OpRem, OpRemu:             fix_val = r_fix;
            default:                   fix_val = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (accept) state_d = fast ? StDone : StCalc;
                StCalc:  if (cnt_q == '0) state_d = StFix;
                StFix:   state_d = StDone;
                StDone:  state_d = accept ? (fast ? StDone : StCalc) : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        ready_o = (state_q == StIdle) | (state_q == StDone);
        valid_o = (state_q == StDone);
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            prod_q <= '0;
            y_q    <= '0;
            zero_q <= 1'b1;
        end else if (accept) begin
            op_q   <= ALUCtrl;
            cnt_q  <= CNT_W'(WIDTH - 1);
            opnd_q <= is_mul ? a_mag : b_mag;
            prod_q <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
            neg_q  <= ((ALUCtrl == OpRem) | (ALUCtrl == OpRemu)) ? sa : (sa ^ sb);
            if (fast) begin
                y_q    <= fast_val;
                zero_q <= (fast_val == '0);
            end
        end else if (!flush) begin
            if (state_q == StCalc) begin
                prod_q <= step_val;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end else if (state_q == StFix) begin
                y_q    <= fix_val;
                zero_q <= (fix_val == '0);
            end
        end
    end

    assign Y    = y_q;
    assign ZERO = zero_q;

endmodule
